// File: rtl/sw_poll_pkg.sv
// Shared definitions for the switch edge poller.
//   poll_state_e : poll sequencer states
//   ADDR_DATA    : PIO data (level) register address
//   ADDR_EDGE    : PIO edge-capture register address
//   CLR_ALL      : write value that clears every capture bit
package sw_poll_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdCap,
      StRdWait,
      StClr,
      StRdLvl,
      StLvlWait,
      StPush
   } poll_state_e;

   localparam logic [1:0]  ADDR_DATA = 2'd0;
   localparam logic [1:0]  ADDR_EDGE = 2'd3;
   localparam logic [31:0] CLR_ALL   = 32'hFFFF_FFFF;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (empties the FIFO)
//   push_i  : write wdata_i (ignored when full)
//   wdata_i : write data
//   pop_i   : drop the head entry (ignored when empty)
//   rdata_o : head entry, valid while !empty_o
//   full_o  : no free entry
//   empty_o : no stored entry
// Depth must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    count_q;
   logic             push_ok, pop_ok;

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == FullCnt);
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/sw_edge_poller.sv
// Periodically polls a PIO edge-capture register and queues switch events.
//   clk, reset              : clock, synchronous active-high reset
//   enable                  : polling enable (also gates irq)
//   m_address/m_chipselect/
//   m_write_n/m_writedata   : PIO master bus (idle = all zero, write_n high)
//   m_readdata              : PIO read data, one-cycle latency
//   evt_valid/evt_ready/
//   evt_data                : FWFT event stream, data = {level, capture}
//   irq                     : registered (events pending) & enable
//   busy                    : poll sequence in progress
module sw_edge_poller
   import sw_poll_pkg::*;
#(
   parameter int unsigned WIDTH      = 18,
   parameter int unsigned POLL_DIV   = 50000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   output logic [1:0]         m_address,
   output logic               m_chipselect,
   output logic               m_write_n,
   output logic [31:0]        m_writedata,
   input  logic [31:0]        m_readdata,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [2*WIDTH-1:0] evt_data,
   output logic               irq,
   output logic               busy
);

   localparam int unsigned CntW = $clog2(POLL_DIV);
   localparam logic [CntW-1:0] LastCnt = CntW'(POLL_DIV - 1);

   poll_state_e      state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] lvl_q, lvl_d;
   logic             irq_q;
   logic             fifo_push, fifo_full, fifo_empty;
   logic             unused_readdata;

   // Upper read-data bits are beyond the serviced switch width.
   assign unused_readdata = ^m_readdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         cap_q   <= '0;
         lvl_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
         lvl_q   <= lvl_d;
         irq_q   <= !fifo_empty && enable;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cap_d        = cap_q;
      lvl_d        = lvl_q;
      fifo_push    = 1'b0;
      m_address    = ADDR_DATA;
      m_chipselect = 1'b0;
      m_write_n    = 1'b1;
      m_writedata  = '0;

      case (state_q)
         StIdle: begin
            // A full FIFO stalls polling; edges simply stay latched in the PIO.
            if (enable && !fifo_full) begin
               if (cnt_q == LastCnt) begin
                  cnt_d   = '0;
                  state_d = StRdCap;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = '0;
            end
         end
         StRdCap: begin
            m_address    = ADDR_EDGE;
            m_chipselect = 1'b1;
            state_d      = StRdWait;
         end
         StRdWait: begin
            cap_d   = m_readdata[WIDTH-1:0];
            state_d = (cap_d == '0) ? StIdle : StClr;
         end
         StClr: begin
            m_address    = ADDR_EDGE;
            m_chipselect = 1'b1;
            m_write_n    = 1'b0;
            m_writedata  = CLR_ALL;
            state_d      = StRdLvl;
         end
         StRdLvl: begin
            m_address    = ADDR_DATA;
            m_chipselect = 1'b1;
            state_d      = StLvlWait;
         end
         StLvlWait: begin
            lvl_d   = m_readdata[WIDTH-1:0];
            state_d = StPush;
         end
         StPush: begin
            fifo_push = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Keep the bus quiet while reset is held so an interrupted clear never
      // reaches the PIO and unreported capture bits survive.
      if (reset) begin
         m_address    = ADDR_DATA;
         m_chipselect = 1'b0;
         m_write_n    = 1'b1;
         m_writedata  = '0;
      end
   end

   sync_fifo #(
      .Width (2 * WIDTH),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (fifo_push),
      .wdata_i ({lvl_q, cap_q}),
      .pop_i   (evt_valid && evt_ready),
      .rdata_o (evt_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign evt_valid = !fifo_empty;
   assign irq       = irq_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_sw_edge_poller.sv
// Bench for sw_edge_poller: PIO model with edge capture, scoreboard of
// expected events built from the switch history, and bus/handshake checks.
module tb_sw_edge_poller;

   localparam int unsigned W     = 18;
   localparam int unsigned PD    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned BOUND = 4 * PD + 8;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           enable = 1'b0;
   logic           evt_ready = 1'b0;
   logic [1:0]     m_address;
   logic           m_chipselect, m_write_n;
   logic [31:0]    m_writedata, m_readdata;
   logic           evt_valid, irq, busy;
   logic [2*W-1:0] evt_data;

   always #5 clk = ~clk;

   sw_edge_poller #(
      .WIDTH      (W),
      .POLL_DIV   (PD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .m_address    (m_address),
      .m_chipselect (m_chipselect),
      .m_write_n    (m_write_n),
      .m_writedata  (m_writedata),
      .m_readdata   (m_readdata),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_data     (evt_data),
      .irq          (irq),
      .busy         (busy)
   );

   // PIO: level register plus rising-edge capture; a write to address 3 clears.
   logic [W-1:0] sw = '0;
   logic [W-1:0] sw_prev = '0;
   logic [W-1:0] edge_q = '0;
   logic [31:0]  rdata_q = '0;
   assign m_readdata = rdata_q;

   always @(posedge clk) begin
      sw_prev <= sw;
      if (m_chipselect && !m_write_n && m_address == 2'd3) edge_q <= '0;
      else edge_q <= edge_q | (sw & ~sw_prev);
      if (m_chipselect && m_write_n)
         rdata_q <= (m_address == 2'd0) ? 32'(sw) : (m_address == 2'd3) ? 32'(edge_q) : 32'h0;
   end

   // Reference model: rising edges not yet reported, and the queue of events
   // that the consumer side must see, in order.
   logic [W-1:0]   pending = '0;
   logic [2*W-1:0] exp_q[$];
   int             errors = 0;
   int             checks = 0;
   int             rdcap_cnt = 0;
   int             clr_cnt = 0;
   bit             rand_ready = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on each accepted event and watches the bus.
   always @(negedge clk) begin
      if (!reset) begin
         if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL evt_unexpected: got data %0h, expected no event", evt_data);
            end else begin
               check("evt_data", 64'(evt_data), 64'(exp_q.pop_front()));
            end
         end
         if (m_chipselect && m_write_n && m_address == 2'd3) rdcap_cnt++;
         if (m_chipselect && !m_write_n) clr_cnt++;
         if (!m_chipselect)
            check("bus_idle", 64'({m_address, m_write_n, m_writedata}), 64'({2'b00, 1'b1, 32'h0}));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) evt_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic apply_sw(input logic [W-1:0] v);
      pending = pending | (v & ~sw);
      sw = v;
      step();
   endtask

   task automatic pulse(input int bitn);
      logic [W-1:0] b;
      b = W'(1) << bitn;
      apply_sw(sw | b);
      apply_sw(sw & ~b);
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, 64'({evt_valid, irq, busy, m_chipselect, m_write_n, m_address, m_writedata}),
            64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0}));
   endtask

   // Waits for the next poll and follows it to completion. If none starts, that
   // is legal only while the model FIFO is full or polling is disabled.
   task automatic wait_poll(input bit ready_at_push);
      int n = 0;
      int space = 0;
      bit started = 0;
      bit was_empty;
      while (!started) begin
         if (m_chipselect && m_write_n && m_address == 2'd3) begin
            started = 1;
         end else begin
            if (enable && exp_q.size() < DEPTH && !busy) space++;
            else space = 0;
            if (space > PD + 3) break;
            if (n >= BOUND && space == 0) break;
            if (n >= 8 * BOUND) break;
            n++;
            step();
         end
      end
      if (!started) begin
         check("poll_missing", 64'(space > PD + 3), 64'(0));
         return;
      end
      check("poll_room", 64'(exp_q.size() < DEPTH), 64'(1));
      was_empty = (exp_q.size() == 0) && !evt_valid;
      if (pending != '0) begin
         exp_q.push_back({sw, pending});
         pending = '0;
         step();
         step();
         check("clr_write", 64'({m_chipselect, m_write_n, m_address, m_writedata}),
               64'({1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF}));
         step();
         check("lvl_read", 64'({m_chipselect, m_write_n, m_address}), 64'({1'b1, 1'b1, 2'd0}));
         step();
         step();
         check("busy_push", 64'(busy), 64'(1));
         if (was_empty) check("valid_before", 64'(evt_valid), 64'(0));
         if (ready_at_push) evt_ready = 1'b1;
         step();
         if (ready_at_push) evt_ready = 1'b0;
         if (was_empty) check("valid_latency", 64'(evt_valid), 64'(1));
         check("busy_end", 64'(busy), 64'(0));
      end else begin
         step();
         check("busy_wait", 64'(busy), 64'(1));
         step();
         check("no_clr", 64'({busy, m_chipselect}), 64'(0));
      end
   endtask

   task automatic drain();
      int n = 0;
      evt_ready = 1'b1;
      while (evt_valid && n < 64) begin
         step();
         n++;
      end
      check("drain", 64'(evt_valid), 64'(0));
   endtask

   initial begin
      int rc, cc, n;
      logic [W-1:0] v, p;

      repeat (3) step();
      check_reset_outputs("reset_state");
      reset = 1'b0;
      enable = 1'b1;
      evt_ready = 1'b1;

      // Level first, then a pulse on bit 5: capture 0x20 with level kept.
      apply_sw(18'h03000);
      wait_poll(0);
      pulse(5);
      wait_poll(0);

      // Quiet periods: reads of the capture register only.
      rc = rdcap_cnt;
      cc = clr_cnt;
      repeat (3) wait_poll(0);
      check("quiet_rdcap", 64'(rdcap_cnt - rc), 64'(3));
      check("quiet_clr", 64'(clr_cnt - cc), 64'(0));
      check("quiet_valid", 64'(evt_valid), 64'(0));

      // Back-pressure: four events fill the FIFO, the fifth edge waits.
      evt_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pulse(i);
         wait_poll(0);
      end
      check("full_valid", 64'(evt_valid), 64'(1));
      check("bit4_latched", 64'(edge_q[4]), 64'(1));
      check("full_queue", 64'(exp_q.size()), 64'(DEPTH));
      evt_ready = 1'b1;
      wait_poll(0);
      drain();

      // Push and pop in the same cycle at occupancy 1.
      evt_ready = 1'b0;
      pulse(6);
      wait_poll(0);
      pulse(7);
      wait_poll(1);
      check("occ_after_pushpop", 64'(evt_valid), 64'(1));
      repeat (3) step();
      check("occ_hold", 64'(evt_valid), 64'(1));
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      check("occ_one", 64'(evt_valid), 64'(0));

      // Enable gating of polling and irq.
      pulse(9);
      wait_poll(0);
      step();
      check("irq_pending", 64'(irq), 64'(1));
      enable = 1'b0;
      step();
      check("irq_disabled", 64'(irq), 64'(0));
      rc = rdcap_cnt;
      pulse(10);
      repeat (3 * PD) step();
      check("disabled_no_bus", 64'(rdcap_cnt - rc), 64'(0));
      check("disabled_valid", 64'(evt_valid), 64'(1));
      enable = 1'b1;
      step();
      check("irq_enabled", 64'(irq), 64'(1));
      evt_ready = 1'b1;
      wait_poll(0);
      drain();

      // Reset during the clear write: sequence aborts, the edge survives.
      evt_ready = 1'b0;
      pulse(11);
      wait_poll(0);
      pulse(14);
      n = 0;
      while (!(m_chipselect && m_write_n && m_address == 2'd3) && n < BOUND) begin
         step();
         n++;
      end
      check("rdcap_seen", 64'(n < BOUND), 64'(1));
      step();
      step();
      reset = 1'b1;
      step();
      check_reset_outputs("reset_in_clr");
      exp_q.delete();
      check("bit14_latched", 64'(edge_q[14]), 64'(1));
      reset = 1'b0;
      evt_ready = 1'b1;
      wait_poll(0);
      drain();

      // Randomised periods with random consumer back-pressure.
      rand_ready = 1;
      for (int k = 0; k < 40; k++) begin
         v = W'($urandom);
         p = W'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 3) == 0) v = sw;
         if ($urandom_range(0, 1) == 1) apply_sw(v | p);
         apply_sw(v);
         wait_poll(0);
      end
      rand_ready = 0;
      drain();
      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sw_edge_poller.md
SW_EDGE_POLLER -- requirements
Module: sw_edge_poller

Interface
REQ-001 SHALL have parameter WIDTH, default 18; number of switch bits serviced.
REQ-002 SHALL have parameter POLL_DIV, default 50000; clocks between poll starts (1 ms at 50 MHz), legal range 8..2^20.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4; event FIFO entries, power of two.
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock; one clock; reset is synchronous and active-high
- reset  in  1  synchronous, active-high reset
- enable  in  1  polling enable
- m_address  out  2  PIO register select
- m_chipselect  out  1  PIO access strobe
- m_write_n  out  1  PIO write, active-low
- m_writedata  out  32  PIO write data
- m_readdata  in  32  PIO read data; fixed one-cycle latency; no waitrequest
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_data  out  2*WIDTH  {level[WIDTH-1:0], capture[WIDTH-1:0]}
- irq  out  1  level interrupt
- busy  out  1  poll sequence in progress

Function
REQ-005 SHALL sequence one PIO with: data register at address 0, edge-capture register at address 3; any write to address 3 clears all capture bits.
REQ-006 SHALL implement states IDLE, RD_CAP, RD_WAIT, CLR, RD_LVL, LVL_WAIT, PUSH.
REQ-007 In IDLE, the poll counter SHALL increment only while enable=1 and the FIFO is not full; otherwise it SHALL hold at 0.
REQ-008 At count POLL_DIV-1, the block SHALL zero the counter and go to RD_CAP.
REQ-009 RD_CAP SHALL drive m_address=3, m_chipselect=1, m_write_n=1 for exactly one cycle.
REQ-010 RD_WAIT SHALL register cap = m_readdata[WIDTH-1:0]; if cap=0, go to IDLE, else go to CLR.
REQ-011 CLR SHALL drive m_address=3, m_chipselect=1, m_write_n=0, m_writedata=all ones for exactly one cycle.
REQ-012 RD_LVL SHALL drive m_address=0, m_chipselect=1, m_write_n=1 for one cycle.
REQ-013 LVL_WAIT SHALL register lvl = m_readdata[WIDTH-1:0].
REQ-014 PUSH SHALL write {lvl, cap} into the FIFO in one cycle, then return to IDLE.
REQ-015 Outside RD_CAP, CLR and RD_LVL: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
REQ-016 Timing: poll start to PUSH is 5 cycles; evt_valid SHALL rise the cycle after PUSH.
REQ-017 FIFO full: no poll SHALL start; edges stay latched in the PIO; no event is lost, and a write is never attempted into a full FIFO.
REQ-018 Known limitation: an edge latched by the PIO during the RD_WAIT cycle SHALL be cleared by CLR without being reported.
REQ-019 evt_data/evt_valid SHALL be a first-word-fall-through head; an entry pops when evt_valid & evt_ready.
REQ-020 A simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-021 irq SHALL be registered and equal (FIFO non-empty) & enable.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 If enable falls mid-sequence, the sequence SHALL complete, and the counter SHALL then hold at 0.

Reset
REQ-024 On reset=1 at a clk edge: state=IDLE, counter=0, cap=lvl=0, FIFO empty, evt_valid=0, irq=0, busy=0, bus outputs per REQ-015.
REQ-025 Reset mid-sequence SHALL abort the sequence with no partial push; PIO capture bits not yet cleared remain set.

Structure
REQ-026 Package sw_poll_pkg SHALL hold the state enum, the constants ADDR_DATA=0 and ADDR_EDGE=3, and the CLR_ALL write constant.
REQ-027 The FIFO SHALL be the sub-module sync_fifo (parameters width and depth; synchronous active-high reset; full/empty flags); the FSM and counter stay in the top level.

Verification
REQ-028 POLL_DIV=8, PIO model; pulse bit 5 high then low -> a write to address 3 follows; evt_data capture=0x00020 with the correct level; evt_valid 6 cycles after poll start.
REQ-029 No edges for 3 poll periods -> only RD_CAP reads occur, no CLR, evt_valid stays 0.
REQ-030 evt_ready=0, with edges on bits 0,1,2,3,4 in 5 successive periods -> 4 events queued, then polling stalls; bit 4 stays latched; release evt_ready -> 5th event has capture=0x00010.
REQ-031 enable=0 -> no bus activity and irq=0 with the FIFO non-empty; enable=1 -> irq=1 next cycle.
REQ-032 Assert reset during CLR -> all outputs take reset values next cycle; FIFO empty; the next poll reports the still-latched bit.
REQ-033 evt_ready=1 with a push in the same cycle as a pop at occupancy 1 -> occupancy stays 1, and data order is preserved.
